decode_execute_stage: RTL and testbench

//   Combined LEGv8 decode + execute stage of the single-cycle 64-bit CPU; sits between iFetch and iMemory/iWriteBack.

---
 rtl/decode_execute_stage.sv | 138 +++++++++++++
 tb/tb_decode_execute_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/decode_execute_stage.sv
// LEGv8 decode + execute for the single-cycle CPU: control/immediate decode,
// 32x64 register file (X31 = XZR), ALU, zero flag and PC-relative branch target.
module decode_execute_stage #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic [WORD-1:0]      cur_pc,
  input  logic [WORD-1:0]      write_data,
  output logic [10:0]          opcode,
  output logic [WORD-1:0]      sign_extended_output,
  output logic                 reg2_loc,
  output logic                 uncondbranch,
  output logic                 branch,
  output logic                 mem_read,
  output logic                 mem_to_reg,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic [1:0]           alu_op,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2,
  output logic [WORD-1:0]      branch_target,
  output logic [WORD-1:0]      alu_result,
  output logic                 zero
);
  localparam int RIDX = $clog2(NUM_REGS);
  localparam logic [RIDX-1:0] XZR = RIDX'(NUM_REGS-1);

  typedef struct packed {
    logic       reg2_loc;
    logic       uncondbranch;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef enum logic [2:0] {FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_LSL, FN_LSR} alu_fn_t;

  ctrl_t           ctrl;
  alu_fn_t         fn;
  logic [WORD-1:0] imm;
  logic [WORD-1:0] alu_b;
  logic [RIDX-1:0] rs1, rs2, rd;
  logic [WORD-1:0] regs [NUM_REGS];

  assign opcode = instruction[31:21];

  always_comb begin
    ctrl = '0;
    fn   = FN_ADD;
    imm  = '0;
    casez (opcode)
      11'b10001011000: begin ctrl.reg_write = 1'b1; ctrl.alu_op = 2'b10; fn = FN_ADD; end
      11'b11001011000: begin ctrl.reg_write = 1'b1; ctrl.alu_op = 2'b10; fn = FN_SUB; end
      11'b10001010000: begin ctrl.reg_write = 1'b1; ctrl.alu_op = 2'b10; fn = FN_AND; end
      11'b10101010000: begin ctrl.reg_write = 1'b1; ctrl.alu_op = 2'b10; fn = FN_ORR; end
      11'b11010011011, 11'b11010011010: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = 2'b10;
        fn  = opcode[0] ? FN_LSL : FN_LSR;
        imm = {{(WORD-6){1'b0}}, instruction[15:10]};
      end
      11'b1001000100?, 11'b1101000100?: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = 2'b10;
        fn  = opcode[9] ? FN_SUB : FN_ADD;
        imm = {{(WORD-12){1'b0}}, instruction[21:10]};
      end
      11'b11111000010: begin
        ctrl.alu_src = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1;
        imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
      end
      11'b11111000000: begin
        ctrl.reg2_loc = 1'b1; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
        imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
      end
      11'b10110100???: begin
        ctrl.reg2_loc = 1'b1; ctrl.branch = 1'b1; ctrl.alu_op = 2'b01;
        imm = {{(WORD-19){instruction[23]}}, instruction[23:5]};
      end
      11'b000101?????: begin
        ctrl.uncondbranch = 1'b1; ctrl.alu_op = 2'b01;
        imm = {{(WORD-26){instruction[25]}}, instruction[25:0]};
      end
      default: ;
    endcase
  end

  assign {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg,
          mem_write, alu_src, reg_write, alu_op} = ctrl;
  assign sign_extended_output = imm;
  assign branch_target        = cur_pc + (imm << 2);

  // Register file: combinational reads, XZR hardwired to zero on read.
  assign rs1 = instruction[9:5];
  assign rs2 = ctrl.reg2_loc ? instruction[4:0] : instruction[20:16];
  assign rd  = instruction[4:0];
  assign read_data1 = (rs1 == XZR) ? '0 : regs[rs1];
  assign read_data2 = (rs2 == XZR) ? '0 : regs[rs2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (ctrl.reg_write && rd != XZR) begin
      regs[rd] <= write_data;
    end
  end

  assign alu_b = ctrl.alu_src ? imm : read_data2;

  always_comb begin
    alu_result = '0;
    case (ctrl.alu_op)
      2'b00: alu_result = read_data1 + alu_b;
      2'b01: alu_result = alu_b;
      2'b10: begin
        case (fn)
          FN_ADD:  alu_result = read_data1 + alu_b;
          FN_SUB:  alu_result = read_data1 - alu_b;
          FN_AND:  alu_result = read_data1 & alu_b;
          FN_ORR:  alu_result = read_data1 | alu_b;
          FN_LSL:  alu_result = read_data1 << alu_b[5:0];
          FN_LSR:  alu_result = read_data1 >> alu_b[5:0];
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);
endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage: directed instructions push
// expectations; a negedge monitor pops and compares the selected fields.
module tb_decode_execute_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic [63:0] cur_pc = '0, write_data = '0;
  logic [10:0] opcode;
  logic [63:0] sign_extended_output, read_data1, read_data2, branch_target, alu_result;
  logic        reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, zero;
  logic [1:0]  alu_op;

  decode_execute_stage dut (
    .clk(clk), .reset(reset), .instruction(instruction), .cur_pc(cur_pc),
    .write_data(write_data), .opcode(opcode), .sign_extended_output(sign_extended_output),
    .reg2_loc(reg2_loc), .uncondbranch(uncondbranch), .branch(branch),
    .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
    .read_data1(read_data1), .read_data2(read_data2), .branch_target(branch_target),
    .alu_result(alu_result), .zero(zero)
  );

  always #5 clk = ~clk;

  // ctrl bits: reg2_loc uncond branch mem_read mem_to_reg mem_write alu_src reg_write alu_op[1:0]
  localparam logic [9:0] C_R  = 10'b0000000110;
  localparam logic [9:0] C_I  = 10'b0000001110;
  localparam logic [9:0] C_LD = 10'b0001101100;
  localparam logic [9:0] C_ST = 10'b1000011000;
  localparam logic [9:0] C_CB = 10'b1010000001;
  localparam logic [9:0] C_B  = 10'b0100000001;
  localparam logic [9:0] C_0  = 10'b0000000000;
  localparam int E_ALU = 1, E_CTL = 2, E_BT = 4, E_RD1 = 8, E_RD2 = 16, E_IMM = 32;

  typedef struct {
    string       name;
    int          en;
    logic [63:0] alu;
    logic        z;
    logic [9:0]  ctl;
    logic [63:0] bt, rd1, rd2, imm;
  } exp_t;

  exp_t q[$];
  logic chk = 1'b0;
  int   tests = 0, fails = 0;

  function automatic logic [31:0] enc_r(logic [10:0] opc, logic [4:0] rm, logic [5:0] sh, logic [4:0] rn, logic [4:0] rd);
    return {opc, rm, sh, rn, rd};
  endfunction
  function automatic logic [31:0] enc_i(logic [9:0] opc, logic [11:0] imm, logic [4:0] rn, logic [4:0] rd);
    return {opc, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(logic [10:0] opc, logic [8:0] imm, logic [4:0] rn, logic [4:0] rt);
    return {opc, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_cb(logic [18:0] imm, logic [4:0] rt);
    return {8'b10110100, imm, rt};
  endfunction
  function automatic logic [31:0] enc_b(logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  function automatic exp_t mk(string n, int en, logic [63:0] alu, logic z, logic [9:0] ctl,
                              logic [63:0] bt, logic [63:0] rd1, logic [63:0] rd2, logic [63:0] imm);
    exp_t e;
    e.name = n; e.en = en; e.alu = alu; e.z = z; e.ctl = ctl;
    e.bt = bt; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
    return e;
  endfunction

  task automatic issue(logic [31:0] ins, logic [63:0] pc, logic [63:0] wd, logic rst_v, exp_t e);
    @(posedge clk); #1;
    instruction = ins; cur_pc = pc; write_data = wd; reset = rst_v;
    q.push_back(e);
    chk = 1'b1;
  endtask

  task automatic cmp(string n, string f, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", n, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard: output with no expectation queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        if ((e.en & E_ALU) != 0) begin
          cmp(e.name, "alu_result", alu_result, e.alu);
          cmp(e.name, "zero", 64'(zero), 64'(e.z));
        end
        if ((e.en & E_CTL) != 0)
          cmp(e.name, "ctrl", 64'({reg2_loc, uncondbranch, branch, mem_read, mem_to_reg,
                                    mem_write, alu_src, reg_write, alu_op}), 64'(e.ctl));
        if ((e.en & E_BT)  != 0) cmp(e.name, "branch_target", branch_target, e.bt);
        if ((e.en & E_RD1) != 0) cmp(e.name, "read_data1", read_data1, e.rd1);
        if ((e.en & E_RD2) != 0) cmp(e.name, "read_data2", read_data2, e.rd2);
        if ((e.en & E_IMM) != 0) cmp(e.name, "imm", sign_extended_output, e.imm);
      end
    end
  end

  initial begin
    int budget;
    // reset state: all registers read zero
    issue(enc_r(11'b10101010000, 5'd2, 6'd0, 5'd1, 5'd5), 0, 64'd0, 1'b1,
          mk("reset_orr", E_ALU|E_CTL|E_RD1|E_RD2, 0, 1, C_R, 0, 0, 0, 0));
    issue(32'h9100E7E1, 0, 64'd57, 1'b0,
          mk("addi_x1", E_ALU|E_CTL|E_RD1|E_IMM, 57, 0, C_I, 0, 0, 0, 57));
    issue(enc_i(10'b1001000100, 12'd8, 5'd31, 5'd3), 0, 64'd8, 1'b0,
          mk("addi_x3", E_ALU, 8, 0, C_0, 0, 0, 0, 0));
    issue(enc_i(10'b1001000100, 12'd100, 5'd31, 5'd5), 0, 64'd100, 1'b0,
          mk("addi_x5", E_ALU, 100, 0, C_0, 0, 0, 0, 0));
    issue(enc_r(11'b11001011000, 5'd3, 6'd0, 5'd1, 5'd2), 0, 64'd0, 1'b0,
          mk("sub_49", E_ALU|E_CTL|E_RD1|E_RD2, 49, 0, C_R, 0, 57, 8, 0));
    issue(enc_r(11'b11001011000, 5'd1, 6'd0, 5'd1, 5'd4), 0, 64'd0, 1'b0,
          mk("sub_zero", E_ALU, 0, 1, C_0, 0, 0, 0, 0));
    issue(enc_cb(19'd3, 5'd2), 64'h40, 64'd0, 1'b0,
          mk("cbz_taken", E_ALU|E_CTL|E_BT|E_RD2|E_IMM, 0, 1, C_CB, 64'h4C, 0, 0, 3));
    issue(enc_i(10'b1001000100, 12'd7, 5'd31, 5'd2), 0, 64'd7, 1'b0,
          mk("addi_x2", E_ALU, 7, 0, C_0, 0, 0, 0, 0));
    issue(enc_cb(19'd3, 5'd2), 64'h40, 64'd0, 1'b0,
          mk("cbz_not", E_ALU|E_BT|E_RD2, 7, 0, C_0, 64'h4C, 0, 7, 0));
    issue(enc_b(26'h3FFFFFE), 64'h20, 64'd0, 1'b0,
          mk("b_back", E_CTL|E_BT|E_IMM, 0, 0, C_B, 64'h18, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE));
    issue(enc_d(11'b11111000000, 9'd8, 5'd1, 5'd5), 0, 64'd999, 1'b0,
          mk("stur", E_ALU|E_CTL|E_RD1|E_RD2|E_IMM, 65, 0, C_ST, 0, 57, 100, 8));
    issue(enc_d(11'b11111000010, 9'h1F8, 5'd1, 5'd6), 0, 64'hAA, 1'b0,
          mk("ldur_neg", E_ALU|E_CTL|E_IMM, 49, 0, C_LD, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8));
    issue(enc_r(11'b10001010000, 5'd5, 6'd0, 5'd6, 5'd7), 0, 64'd0, 1'b0,
          mk("and", E_ALU|E_RD1|E_RD2, 64'h20, 0, C_0, 0, 64'hAA, 100, 0));
    issue(enc_r(11'b10101010000, 5'd5, 6'd0, 5'd6, 5'd7), 0, 64'd0, 1'b0,
          mk("orr", E_ALU, 64'hEE, 0, C_0, 0, 0, 0, 0));
    issue(enc_r(11'b11010011011, 5'd0, 6'd4, 5'd1, 5'd8), 0, 64'd0, 1'b0,
          mk("lsl4", E_ALU|E_CTL|E_IMM, 912, 0, C_I, 0, 0, 0, 4));
    issue(enc_r(11'b11010011011, 5'd0, 6'd63, 5'd1, 5'd8), 0, 64'd0, 1'b0,
          mk("lsl63", E_ALU, 64'h8000_0000_0000_0000, 0, C_0, 0, 0, 0, 0));
    issue(enc_r(11'b11010011010, 5'd0, 6'd3, 5'd1, 5'd9), 0, 64'd0, 1'b0,
          mk("lsr3", E_ALU|E_CTL, 7, 0, C_I, 0, 0, 0, 0));
    issue(enc_i(10'b1101000100, 12'd60, 5'd1, 5'd13), 0, 64'd0, 1'b0,
          mk("subi_wrap", E_ALU|E_CTL, 64'hFFFF_FFFF_FFFF_FFFD, 0, C_I, 0, 0, 0, 0));
    issue(enc_i(10'b1001000100, 12'd5, 5'd31, 5'd31), 0, 64'd123, 1'b0,
          mk("wr_xzr", E_ALU, 5, 0, C_0, 0, 0, 0, 0));
    issue(enc_r(11'b10001011000, 5'd31, 6'd0, 5'd31, 5'd10), 0, 64'd0, 1'b0,
          mk("rd_xzr", E_ALU|E_RD1|E_RD2, 0, 1, C_0, 0, 0, 0, 0));
    issue(32'h0000_0000, 0, 64'd55, 1'b0,
          mk("unknown", E_CTL|E_IMM, 0, 0, C_0, 0, 0, 0, 0));
    // reset asserted between edges: reads clear immediately
    issue(enc_r(11'b10001011000, 5'd5, 6'd0, 5'd1, 5'd11), 0, 64'd0, 1'b1,
          mk("rst_mid", E_ALU|E_RD1|E_RD2, 0, 1, C_0, 0, 0, 0, 0));
    issue(enc_i(10'b1001000100, 12'd9, 5'd31, 5'd1), 0, 64'd9, 1'b1,
          mk("rst_wr", E_ALU|E_CTL, 9, 0, C_I, 0, 0, 0, 0));
    issue(enc_r(11'b10001011000, 5'd5, 6'd0, 5'd1, 5'd12), 0, 64'd0, 1'b0,
          mk("post_rst", E_RD1|E_RD2, 0, 0, C_0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk = 1'b0;
    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
